// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : shared widths, request type and helpers for the writeback port.
// Rev 1.0
// ============================================================================
package wb_pkg;

  localparam int WB_AW = 5;
  localparam int WB_DW = 32;

  localparam logic [WB_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
  } wb_req_t;

  function automatic logic [31:0] reg_onehot(input logic [WB_AW-1:0] a);
    reg_onehot = 32'd1 << a;
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// wb_fifo : DEPTH-entry load-writeback queue with per-slot valid/addr export.
// Rev 1.0
// ============================================================================
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  wb_req_t          i_din,
  input  logic             i_pop,
  output wb_req_t          o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [DEPTH-1:0] o_vld,
  output logic [WB_AW-1:0] o_addr [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] c_PTR_ONE = 1;
  localparam logic [PW:0]   c_CNT_ONE = 1;
  localparam logic [PW:0]   c_FULL    = DEPTH;

  wb_req_t          r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [PW:0]      r_count;
  logic             r_full;
  logic [DEPTH-1:0] r_vld;

  logic             w_push;
  logic             w_pop;
  logic [PW:0]      w_count_nxt;

  assign w_push = i_push & ~r_full;
  assign w_pop  = i_pop & (r_count != '0);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + c_CNT_ONE;
      2'b01:   w_count_nxt = r_count - c_CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Full is registered from the next count, so a pop never re-opens ready in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_vld   <= '0;
    end else begin
      if (w_push) begin
        r_wptr        <= r_wptr + c_PTR_ONE;
        r_vld[r_wptr] <= 1'b1;
      end
      if (w_pop) begin
        r_rptr        <= r_rptr + c_PTR_ONE;
        r_vld[r_rptr] <= 1'b0;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == c_FULL);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_din;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_addr
    assign o_addr[gi] = r_mem[gi].addr;
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = r_full;
  assign o_empty = (r_count == '0);
  assign o_vld   = r_vld;

endmodule
`default_nettype wire

// File: rtl/wb_port_ctrl.sv
`default_nettype none
// ============================================================================
// wb_port_ctrl : merges ALU and queued load writebacks onto one regfile port.
// Rev 1.0
// ============================================================================
module wb_port_ctrl
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          alu_wb_valid_i,
  input  logic [AW-1:0] alu_wb_addr_i,
  input  logic [DW-1:0] alu_wb_data_i,
  input  logic          mem_wb_valid_i,
  output logic          mem_wb_ready_o,
  input  logic [AW-1:0] mem_wb_addr_i,
  input  logic [DW-1:0] mem_wb_data_i,
  output logic          w_en_o,
  output logic [31:0]   w_addr_o,
  output logic [DW-1:0] w_data_o,
  output logic [31:0]   pend_o,
  output logic          order_err_o
);

  wb_req_t          w_push_req;
  wb_req_t          w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [DEPTH-1:0] w_vld;
  logic [WB_AW-1:0] w_ent_addr [DEPTH];
  logic [31:0]      w_pend;

  logic             w_sel_valid;
  logic [WB_AW-1:0] w_sel_addr;
  logic [DW-1:0]    w_sel_data;
  logic             w_wr;
  logic             w_hazard;

  logic             r_en;
  logic [31:0]      r_addr;
  logic [DW-1:0]    r_data;
  logic             r_err;

  assign w_push_req.addr = mem_wb_addr_i;
  assign w_push_req.data = mem_wb_data_i;
  assign w_push          = mem_wb_valid_i & ~w_full;
  assign w_pop           = ~alu_wb_valid_i & ~w_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (w_push_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_vld   (w_vld),
    .o_addr  (w_ent_addr)
  );

  always_comb begin
    w_pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_vld[i] && (w_ent_addr[i] != REG_ZERO)) begin
        w_pend = w_pend | reg_onehot(w_ent_addr[i]);
      end
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_addr  = w_head.addr;
    w_sel_data  = w_head.data;
    if (alu_wb_valid_i) begin
      w_sel_valid = 1'b1;
      w_sel_addr  = alu_wb_addr_i;
      w_sel_data  = alu_wb_data_i;
    end else if (!w_empty) begin
      w_sel_valid = 1'b1;
    end
  end

  // r0 writes still consume their slot / cycle but never reach the regfile.
  assign w_wr     = w_sel_valid & (w_sel_addr != REG_ZERO);
  assign w_hazard = alu_wb_valid_i & (alu_wb_addr_i != REG_ZERO) & w_pend[alu_wb_addr_i];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_err  <= 1'b0;
    end else begin
      r_en <= w_wr;
      if (w_wr) begin
        r_addr <= {{(32-WB_AW){1'b0}}, w_sel_addr};
        r_data <= w_sel_data;
      end
      if (w_hazard) begin
        r_err <= 1'b1;
      end
    end
  end

  assign mem_wb_ready_o = ~w_full;
  assign pend_o         = w_pend;
  assign w_en_o         = r_en;
  assign w_addr_o       = r_addr;
  assign w_data_o       = r_data;
  assign order_err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wb_port_ctrl.sv
`default_nettype none
// ============================================================================
// tb_wb_port_ctrl : directed + randomized bench against a queue-based model.
// Rev 1.0
// ============================================================================
module tb_wb_port_ctrl;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        alu_v = 1'b0;
  logic [4:0]  alu_a = '0;
  logic [31:0] alu_d = '0;
  logic        mem_v = 1'b0;
  logic [4:0]  mem_a = '0;
  logic [31:0] mem_d = '0;

  logic        ready;
  logic        w_en;
  logic [31:0] w_addr;
  logic [31:0] w_data;
  logic [31:0] pend;
  logic        err;

  wb_port_ctrl #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .reset          (reset),
    .alu_wb_valid_i (alu_v),
    .alu_wb_addr_i  (alu_a),
    .alu_wb_data_i  (alu_d),
    .mem_wb_valid_i (mem_v),
    .mem_wb_ready_o (ready),
    .mem_wb_addr_i  (mem_a),
    .mem_wb_data_i  (mem_d),
    .w_en_o         (w_en),
    .w_addr_o       (w_addr),
    .w_data_o       (w_data),
    .pend_o         (pend),
    .order_err_o    (err)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic        m_en   = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_data = '0;
  logic        m_err  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_pend();
    logic [31:0] p;
    p = '0;
    foreach (mq[i]) if (mq[i].a != 5'd0) p[mq[i].a] = 1'b1;
    return p;
  endfunction

  // Reference: a queue of outstanding loads plus the "ALU first, else oldest load" rule.
  initial begin
    logic [31:0] p;
    bit          do_push;
    ent_t        h;
    ent_t        e;
    forever begin
      @(posedge clk);
      if (!reset) begin
        mq.delete();
        m_en = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
      end else begin
        p       = model_pend();
        do_push = mem_v && (mq.size() < DEPTH);
        if (alu_v && alu_a != 5'd0 && p[alu_a]) m_err = 1'b1;
        m_en = 1'b0;
        if (alu_v) begin
          if (alu_a != 5'd0) begin
            m_en = 1'b1; m_addr = {27'd0, alu_a}; m_data = alu_d;
          end
        end else if (mq.size() > 0) begin
          h = mq.pop_front();
          if (h.a != 5'd0) begin
            m_en = 1'b1; m_addr = {27'd0, h.a}; m_data = h.d;
          end
        end
        if (do_push) begin
          e.a = mem_a; e.d = mem_d;
          mq.push_back(e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      chk("cyc w_en", 32'(w_en), 32'(m_en));
      chk("cyc ready", 32'(ready), 32'(mq.size() < DEPTH));
      chk("cyc pend", pend, model_pend());
      chk("cyc order_err", 32'(err), 32'(m_err));
      if (m_en) begin
        chk("cyc w_addr", w_addr, m_addr);
        chk("cyc w_data", w_data, m_data);
      end
    end
  end

  task automatic drive(input int av, input int aa, input logic [31:0] ad,
                       input int mv, input int ma, input logic [31:0] md);
    @(negedge clk);
    alu_v = (av != 0); alu_a = 5'(aa); alu_d = ad;
    mem_v = (mv != 0); mem_a = 5'(ma); mem_d = md;
  endtask

  task automatic sample();
    @(posedge clk);
    #2;
  endtask

  task automatic vec(input string nm, input int av, input int aa, input logic [31:0] ad,
                     input int mv, input int ma, input logic [31:0] md,
                     input int een, input int eaddr, input logic [31:0] edata,
                     input logic [31:0] epend, input int eerr);
    drive(av, aa, ad, mv, ma, md);
    sample();
    chk({nm, " en"}, 32'(w_en), 32'(een != 0));
    if (een != 0) begin
      chk({nm, " addr"}, w_addr, 32'(eaddr));
      chk({nm, " data"}, w_data, edata);
    end
    chk({nm, " pend"}, pend, epend);
    chk({nm, " err"}, 32'(err), 32'(eerr != 0));
  endtask

  ent_t seen[$];
  int   k;

  initial begin
    // Reset held with valids high
    alu_v = 1'b1; alu_a = 5'd6; alu_d = 32'h1234;
    mem_v = 1'b1; mem_a = 5'd8; mem_d = 32'h5678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    alu_v = 1'b0; mem_v = 1'b0;
    sample();
    chk("rst w_en", 32'(w_en), 32'd0);
    chk("rst ready", 32'(ready), 32'd1);
    chk("rst pend", pend, 32'd0);
    chk("rst err", 32'(err), 32'd0);

    // ALU only, then idle holds address
    vec("alu", 1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 32'hDEADBEEF, 32'h0, 0);
    vec("alu idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    chk("alu hold addr", w_addr, 32'd5);

    // ALU priority over queued loads
    vec("pri0", 1, 7, 32'h70, 1, 3, 32'h11, 1, 7, 32'h70, 32'h08, 0);
    vec("pri1", 1, 7, 32'h71, 1, 4, 32'h22, 1, 7, 32'h71, 32'h18, 0);
    vec("pri2", 1, 7, 32'h72, 0, 0, 0,      1, 7, 32'h72, 32'h18, 0);
    vec("pri3", 1, 7, 32'h73, 0, 0, 0,      1, 7, 32'h73, 32'h18, 0);
    vec("pri4", 0, 0, 0,      0, 0, 0,      1, 3, 32'h11, 32'h10, 0);
    vec("pri5", 0, 0, 0,      0, 0, 0,      1, 4, 32'h22, 32'h00, 0);
    vec("pri6", 0, 0, 0,      0, 0, 0,      0, 0, 0,      32'h00, 0);

    // Full FIFO with ALU busy; fifth load waits
    k = 0;
    seen.delete();
    for (int c = 0; c < 20; c++) begin
      ent_t e;
      @(negedge clk);
      alu_v = (c < 8); alu_a = 5'd1; alu_d = 32'(c);
      if (c == 4) begin
        chk("full ready", 32'(ready), 32'd0);
        chk("full pend", pend, 32'h3C00);
      end
      if (k < 5) begin
        mem_v = 1'b1; mem_a = 5'(10 + k); mem_d = 32'(160 + k);
        if (ready) k++;
      end else begin
        mem_v = 1'b0;
      end
      sample();
      if (w_en && w_addr != 32'd1) begin
        e.a = w_addr[4:0]; e.d = w_data;
        seen.push_back(e);
      end
    end
    chk("full retired", 32'(seen.size()), 32'd5);
    for (int i = 0; i < 5 && i < seen.size(); i++) begin
      chk("full order addr", 32'(seen[i].a), 32'(10 + i));
      chk("full order data", seen[i].d, 32'(160 + i));
    end

    // Register zero from both sources
    vec("r0 alu",  1, 0, 32'h99, 0, 0, 0,      0, 0, 0, 32'h0, 0);
    vec("r0 push", 0, 0, 0,      1, 0, 32'h55, 0, 0, 0, 32'h0, 0);
    vec("r0 pop",  0, 0, 0,      0, 0, 0,      0, 0, 0, 32'h0, 0);
    chk("r0 slot freed", 32'(ready), 32'd1);

    // Ordering hazard, then reset with entries queued
    vec("haz0", 1, 2, 32'h22, 1, 9, 32'h99, 1, 2, 32'h22, 32'h200, 0);
    vec("haz1", 1, 9, 32'h09, 0, 0, 0,      1, 9, 32'h09, 32'h200, 1);
    vec("haz2", 0, 0, 0,      0, 0, 0,      1, 9, 32'h99, 32'h000, 1);
    vec("q0",   1, 3, 32'h33, 1, 11, 32'hB1, 1, 3, 32'h33, 32'h0800, 1);
    vec("q1",   1, 3, 32'h34, 1, 12, 32'hB2, 1, 3, 32'h34, 32'h1800, 1);
    @(negedge clk);
    reset = 1'b0;
    alu_v = 1'b0; mem_v = 1'b0;
    #1;
    chk("mid rst pend", pend, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) vec("post rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) != 0);
      alu_v = ($urandom_range(0, 2) == 0);
      alu_a = 5'($urandom_range(0, 7));
      alu_d = $urandom;
      mem_v = ($urandom_range(0, 1) == 1);
      mem_a = 5'($urandom_range(0, 7));
      mem_d = $urandom;
    end
    @(negedge clk);
    reset = 1'b1; alu_v = 1'b0; mem_v = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
